ipv4_local_lut_req_arb: RTL and testbench
=========================================

// Module: ipv4_local_lut_req_arb
// PURPOSE
//  Shares the single lookup port of the IPv4 local-address LUT between NUM_REQ requesters.
//  Round-robin grant, credit-based flow control against the LUT's 4-deep result FIFO, and an
//  in-order tag FIFO that steers each is_local result back to its requester.
//  Sits between the per-port header parsers and the LUT's daddr / is_local / rd_from_magic port.
// PARAMETERS
//  NUM_REQ         4  number of lookup requesters
//  REQ_BITS        2  width of requester index (>= clog2(NUM_REQ))
//  LUT_CREDITS     4  max lookups outstanding in LUT (= LUT result FIFO depth)
//  CREDIT_BITS     3  credit counter width (holds 0..LUT_CREDITS)
// PORTS
//  clk                 in   1           single clock
//  resetn              in   1           async assert, active-low reset
//  i_req_valid         in   NUM_REQ     per-requester lookup request
//  i_req_daddr         in   32*NUM_REQ  daddr; requester n at [32n+31:32n]
//  o_req_ready         out  NUM_REQ     one-hot grant (comb.); transfer = valid & ready
//  o_rsp_valid         out  NUM_REQ     one-hot 1-cycle result pulse
//  o_rsp_is_local      out  1           result; qualified by |o_rsp_valid
//  o_lut_daddr         out  32          to LUT i_ipv4_local_lut_ipv4_daddr
//  o_lut_daddr_valid   out  1           to LUT daddr_valid; 1-cycle pulse per lookup
//  i_lut_is_local      in   1           from LUT o_ipv4_local_lut_ipv4_daddr_is_local
//  i_lut_is_local_valid in  1           from LUT is_local_valid (result FIFO non-empty)
//  o_lut_rd            out  1           to LUT i_rd_from_magic (comb. pop)
//  o_lookup_cnt        out  32          lookups granted; wraps 0xFFFFFFFF -> 0
//  o_err_orphan        out  1           sticky: LUT result with no outstanding tag
// BEHAVIOUR
//  Reset (resetn=0, async): all outputs 0, credits=LUT_CREDITS, tag FIFO empty, rr pointer
//   so requester 0 has top priority, o_lookup_cnt=0, o_err_orphan=0. In-flight lookups are
//   discarded; top level holds LUT reset (!resetn) concurrently so its FIFO is also flushed.
//  Grant (comb. from regs): if credits>0 and any i_req_valid, grant first valid requester
//   searching from last_grant+1 mod NUM_REQ; else o_req_ready=0. Credits are the registered
//   value only: a pop in the same cycle does not enable a grant at credits==0.
//  Requesters hold valid and daddr stable until ready; ready never asserts without valid.
//  On grant in cycle T: o_lut_daddr<=daddr[g], o_lut_daddr_valid<=1 in T+1 (else 0);
//   push g into tag FIFO (depth 2^REQ_BITS... sized >= LUT_CREDITS); last_grant<=g;
//   credits-1; o_lookup_cnt+1.
//  Response: o_lut_rd = i_lut_is_local_valid & tag FIFO non-empty. On pop in cycle T:
//   o_rsp_valid<=onehot(tag head) and o_rsp_is_local<=i_lut_is_local in T+1; credits+1.
//   Requesters always accept responses (no backpressure). o_rsp_is_local=0 when no pulse.
//  Grant and pop same cycle: credits unchanged; tag push/pop both performed.
//  Orphan: i_lut_is_local_valid with tag FIFO empty -> o_lut_rd=0, o_err_orphan<=1 (sticky
//   until reset), no o_rsp_valid.
//  Invariant: credits + tag FIFO occupancy == LUT_CREDITS at every clock edge.
//  Ordering: responses return in grant order; no reordering.
//  Latency with LUT (2-cycle result): grant T -> o_rsp_valid T+4; throughput 1 lookup/cycle
//   sustained while credits recycle.
// TESTING (bench uses behavioural LUT: result 2 cycles after daddr_valid, 4-deep FIFO)
//  1 Req0 valid daddr 0x0A000001 (local in model) at T -> ready=0001 at T, o_lut_daddr_valid=1
//    with 0x0A000001 at T+1, o_rsp_valid=0001 & o_rsp_is_local=1 at T+4, cnt=1.
//  2 All four valid continuously -> grants 0,1,2,3,0,1,... ; o_rsp_valid order 1,2,4,8,1,...
//  3 Model stalls results -> exactly 4 grants then ready=0000; release one result -> one pop,
//    next cycle exactly one further grant; credits never negative.
//  4 Credits=0, pop and req valid same cycle -> no grant that cycle, grant following cycle.
//  5 is_local_valid forced 1 with no outstanding lookup -> o_lut_rd=0, o_err_orphan=1 and
//    stays 1; no o_rsp_valid.
//  6 resetn low mid-flight (3 outstanding) -> all outputs 0 immediately (async); after release
//    with reqs 2 and 0 valid, req0 granted first and no stale o_rsp_valid appears.

Source files
------------

// File: rtl/ipv4_local_lut_req_arb.sv
// Round-robin arbiter sharing the IPv4 local-address LUT lookup port between NUM_REQ requesters.
// Credits track the LUT result FIFO; an in-order tag FIFO routes each result back to its requester.
module ipv4_local_lut_req_arb #(
   parameter int NUM_REQ     = 4,
   parameter int REQ_BITS    = 2,
   parameter int LUT_CREDITS = 4,
   parameter int CREDIT_BITS = 3
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_REQ-1:0]      i_req_valid,
   input  logic [32*NUM_REQ-1:0]   i_req_daddr,
   output logic [NUM_REQ-1:0]      o_req_ready,
   output logic [NUM_REQ-1:0]      o_rsp_valid,
   output logic                    o_rsp_is_local,
   output logic [31:0]             o_lut_daddr,
   output logic                    o_lut_daddr_valid,
   input  logic                    i_lut_is_local,
   input  logic                    i_lut_is_local_valid,
   output logic                    o_lut_rd,
   output logic [31:0]             o_lookup_cnt,
   output logic                    o_err_orphan
);

   localparam int TAG_DEPTH = LUT_CREDITS;
   localparam int PTR_BITS  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   logic [CREDIT_BITS-1:0] credits_q, credits_d;
   logic [CREDIT_BITS-1:0] tag_cnt_q, tag_cnt_d;
   logic [PTR_BITS-1:0]    tag_wr_ptr_q, tag_wr_ptr_d;
   logic [PTR_BITS-1:0]    tag_rd_ptr_q, tag_rd_ptr_d;
   logic [REQ_BITS-1:0]    tag_mem_q [TAG_DEPTH];
   logic [REQ_BITS-1:0]    last_grant_q, last_grant_d;
   logic [31:0]            lut_daddr_q, lut_daddr_d;
   logic                   lut_daddr_valid_q, lut_daddr_valid_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic                   rsp_is_local_q, rsp_is_local_d;
   logic [31:0]            lookup_cnt_q, lookup_cnt_d;
   logic                   err_orphan_q, err_orphan_d;

   logic [31:0]            req_daddr [NUM_REQ];
   logic [REQ_BITS-1:0]    grant_idx;
   logic                   grant_any;
   logic                   tag_empty;
   logic                   pop;
   logic [REQ_BITS-1:0]    tag_head;
   logic [NUM_REQ-1:0]     head_onehot;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_daddr[gi]   = i_req_daddr[32*gi +: 32];
      assign o_req_ready[gi] = grant_any && (grant_idx == REQ_BITS'(gi));
      assign head_onehot[gi] = (tag_head == REQ_BITS'(gi));
   end

   // Search from last_grant+1 downwards in priority; the nearest valid requester wins.
   // Grant uses only registered credits, so a same-cycle pop cannot unblock credits==0.
   always_comb begin
      int idx;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_grant_q) + k) % NUM_REQ;
         if (i_req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = REQ_BITS'(idx);
         end
      end
      if ((credits_q == '0) || !resetn) begin
         grant_any = 1'b0;
      end
   end

   assign tag_empty = (tag_cnt_q == '0);
   assign tag_head  = tag_mem_q[tag_rd_ptr_q];
   assign pop       = i_lut_is_local_valid && !tag_empty;
   assign o_lut_rd  = pop;

   always_comb begin
      credits_d         = credits_q;
      tag_cnt_d         = tag_cnt_q;
      tag_wr_ptr_d      = tag_wr_ptr_q;
      tag_rd_ptr_d      = tag_rd_ptr_q;
      last_grant_d      = last_grant_q;
      lut_daddr_d       = lut_daddr_q;
      lut_daddr_valid_d = grant_any;
      rsp_valid_d       = pop ? head_onehot : '0;
      rsp_is_local_d    = pop && i_lut_is_local;
      lookup_cnt_d      = lookup_cnt_q;
      err_orphan_d      = err_orphan_q | (i_lut_is_local_valid && tag_empty);

      if (grant_any) begin
         last_grant_d = grant_idx;
         lut_daddr_d  = req_daddr[grant_idx];
         lookup_cnt_d = lookup_cnt_q + 32'd1;
         tag_wr_ptr_d = (tag_wr_ptr_q == PTR_BITS'(TAG_DEPTH-1)) ? '0 : tag_wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) begin
         tag_rd_ptr_d = (tag_rd_ptr_q == PTR_BITS'(TAG_DEPTH-1)) ? '0 : tag_rd_ptr_q + PTR_BITS'(1);
      end

      // A simultaneous grant and pop leaves both counts untouched.
      case ({grant_any, pop})
         2'b10: begin
            credits_d = credits_q - CREDIT_BITS'(1);
            tag_cnt_d = tag_cnt_q + CREDIT_BITS'(1);
         end
         2'b01: begin
            credits_d = credits_q + CREDIT_BITS'(1);
            tag_cnt_d = tag_cnt_q - CREDIT_BITS'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (grant_any) begin
         tag_mem_q[tag_wr_ptr_q] <= grant_idx;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         credits_q         <= CREDIT_BITS'(LUT_CREDITS);
         tag_cnt_q         <= '0;
         tag_wr_ptr_q      <= '0;
         tag_rd_ptr_q      <= '0;
         last_grant_q      <= REQ_BITS'(NUM_REQ-1);
         lut_daddr_q       <= '0;
         lut_daddr_valid_q <= 1'b0;
         rsp_valid_q       <= '0;
         rsp_is_local_q    <= 1'b0;
         lookup_cnt_q      <= '0;
         err_orphan_q      <= 1'b0;
      end else begin
         credits_q         <= credits_d;
         tag_cnt_q         <= tag_cnt_d;
         tag_wr_ptr_q      <= tag_wr_ptr_d;
         tag_rd_ptr_q      <= tag_rd_ptr_d;
         last_grant_q      <= last_grant_d;
         lut_daddr_q       <= lut_daddr_d;
         lut_daddr_valid_q <= lut_daddr_valid_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_is_local_q    <= rsp_is_local_d;
         lookup_cnt_q      <= lookup_cnt_d;
         err_orphan_q      <= err_orphan_d;
      end
   end

   assign o_lut_daddr       = lut_daddr_q;
   assign o_lut_daddr_valid = lut_daddr_valid_q;
   assign o_rsp_valid       = rsp_valid_q;
   assign o_rsp_is_local    = rsp_is_local_q;
   assign o_lookup_cnt      = lookup_cnt_q;
   assign o_err_orphan      = err_orphan_q;

endmodule

// File: tb/tb_ipv4_local_lut_req_arb.sv
// Directed bench for ipv4_local_lut_req_arb with a behavioural LUT
// (result two cycles after daddr_valid, 4-deep result FIFO, stall and orphan controls).
module tb_ipv4_local_lut_req_arb;

   logic         clk;
   logic         resetn;
   logic [3:0]   i_req_valid;
   logic [127:0] i_req_daddr;
   logic [3:0]   o_req_ready;
   logic [3:0]   o_rsp_valid;
   logic         o_rsp_is_local;
   logic [31:0]  o_lut_daddr;
   logic         o_lut_daddr_valid;
   logic         i_lut_is_local;
   logic         i_lut_is_local_valid;
   logic         o_lut_rd;
   logic [31:0]  o_lookup_cnt;
   logic         o_err_orphan;

   int n_cmp = 0;
   int n_mis = 0;

   ipv4_local_lut_req_arb dut (
      .clk                  (clk),
      .resetn               (resetn),
      .i_req_valid          (i_req_valid),
      .i_req_daddr          (i_req_daddr),
      .o_req_ready          (o_req_ready),
      .o_rsp_valid          (o_rsp_valid),
      .o_rsp_is_local       (o_rsp_is_local),
      .o_lut_daddr          (o_lut_daddr),
      .o_lut_daddr_valid    (o_lut_daddr_valid),
      .i_lut_is_local       (i_lut_is_local),
      .i_lut_is_local_valid (i_lut_is_local_valid),
      .o_lut_rd             (o_lut_rd),
      .o_lookup_cnt         (o_lookup_cnt),
      .o_err_orphan         (o_err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural LUT: addresses in 10.0.0.0/8 are local.
   logic       s_valid, s_local;
   logic       m_mem [0:3];
   logic [1:0] m_wp, m_rp;
   logic [2:0] m_cnt;
   logic       m_stall, force_orphan, m_pop;

   function automatic logic model_local(input logic [31:0] a);
      return a[31:24] == 8'h0A;
   endfunction

   assign m_pop                = o_lut_rd && (m_cnt != 3'd0);
   assign i_lut_is_local_valid = force_orphan | ((m_cnt != 3'd0) && !m_stall);
   assign i_lut_is_local       = m_mem[m_rp];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_valid <= 1'b0;
         s_local <= 1'b0;
         m_wp    <= 2'd0;
         m_rp    <= 2'd0;
         m_cnt   <= 3'd0;
         for (int i = 0; i < 4; i++) m_mem[i] <= 1'b0;
      end else begin
         s_valid <= o_lut_daddr_valid;
         s_local <= model_local(o_lut_daddr);
         if (s_valid) begin
            m_mem[m_wp] <= s_local;
            m_wp        <= m_wp + 2'd1;
         end
         if (m_pop) m_rp <= m_rp + 2'd1;
         m_cnt <= m_cnt + {2'b00, s_valid} - {2'b00, m_pop};
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn       = 1'b0;
      i_req_valid  = 4'b0000;
      m_stall      = 1'b0;
      force_orphan = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn       = 1'b0;
      i_req_valid  = 4'b0000;
      i_req_daddr  = '0;
      m_stall      = 1'b0;
      force_orphan = 1'b0;
      #1;
      check_val("rst_ready",   32'(o_req_ready), 32'h0);
      check_val("rst_rsp",     32'(o_rsp_valid), 32'h0);
      check_val("rst_dvalid",  32'(o_lut_daddr_valid), 32'h0);
      check_val("rst_daddr",   o_lut_daddr, 32'h0);
      check_val("rst_cnt",     o_lookup_cnt, 32'h0);
      check_val("rst_orphan",  32'(o_err_orphan), 32'h0);

      // 1: single lookup, latency grant T -> response T+4
      do_reset();
      i_req_daddr[31:0] = 32'h0A000001;
      i_req_valid = 4'b0001;
      #1;
      check_val("t1_ready", 32'(o_req_ready), 32'h1);
      tick();
      i_req_valid = 4'b0000;
      check_val("t1_dvalid", 32'(o_lut_daddr_valid), 32'h1);
      check_val("t1_daddr",  o_lut_daddr, 32'h0A000001);
      check_val("t1_cnt",    o_lookup_cnt, 32'd1);
      #1;
      check_val("t1_ready_off", 32'(o_req_ready), 32'h0);
      tick();
      check_val("t1_dvalid_off", 32'(o_lut_daddr_valid), 32'h0);
      tick();
      check_val("t1_lut_rd", 32'(o_lut_rd), 32'h1);
      check_val("t1_rsp_early", 32'(o_rsp_valid), 32'h0);
      tick();
      check_val("t1_rsp", 32'(o_rsp_valid), 32'h1);
      check_val("t1_local", 32'(o_rsp_is_local), 32'h1);
      $display("txn t1: req0 daddr 0a000001 rsp %b local %b", o_rsp_valid, o_rsp_is_local);
      tick();
      check_val("t1_rsp_off", 32'(o_rsp_valid), 32'h0);
      check_val("t1_local_off", 32'(o_rsp_is_local), 32'h0);

      // 2: all four requesting, round-robin at full throughput
      do_reset();
      i_req_daddr = {32'hC0000003, 32'h0A000002, 32'h0B000001, 32'h0A000010};
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (k >= 4) begin
            check_val($sformatf("t2_rsp%0d", k), 32'(o_rsp_valid), 32'(1 << ((k-4) % 4)));
            check_val($sformatf("t2_loc%0d", k), 32'(o_rsp_is_local), 32'(((k-4) % 2) == 0));
            $display("txn t2: rsp %b local %b", o_rsp_valid, o_rsp_is_local);
         end else begin
            check_val($sformatf("t2_rsp%0d", k), 32'(o_rsp_valid), 32'h0);
         end
         i_req_valid = (k < 12) ? 4'b1111 : 4'b0000;
         #1;
         check_val($sformatf("t2_rdy%0d", k), 32'(o_req_ready), (k < 12) ? 32'(1 << (k % 4)) : 32'h0);
      end
      check_val("t2_cnt", o_lookup_cnt, 32'd12);

      // 3: results stalled -> four grants then blocked; one release -> one more grant
      do_reset();
      m_stall = 1'b1;
      i_req_daddr[63:32] = 32'h0A000101;
      i_req_valid = 4'b0010;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) tick();
         #1;
         check_val($sformatf("t3_rdy%0d", c), 32'(o_req_ready), (c < 4) ? 32'h2 : 32'h0);
      end
      check_val("t3_rd_stalled", 32'(o_lut_rd), 32'h0);
      tick();
      m_stall = 1'b0;
      #1;
      check_val("t3_rd_release", 32'(o_lut_rd), 32'h1);
      check_val("t3_rdy_c7", 32'(o_req_ready), 32'h0);
      tick();
      m_stall = 1'b1;
      check_val("t3_rsp", 32'(o_rsp_valid), 32'h2);
      check_val("t3_local", 32'(o_rsp_is_local), 32'h1);
      #1;
      check_val("t3_rdy_c8", 32'(o_req_ready), 32'h2);
      tick();
      check_val("t3_dvalid", 32'(o_lut_daddr_valid), 32'h1);
      check_val("t3_cnt", o_lookup_cnt, 32'd5);
      #1;
      check_val("t3_rdy_c9", 32'(o_req_ready), 32'h0);

      // 4: credits==0, pop and request in the same cycle -> grant only the next cycle
      tick();
      m_stall = 1'b0;
      #1;
      check_val("t4_rd", 32'(o_lut_rd), 32'h1);
      check_val("t4_rdy_pop", 32'(o_req_ready), 32'h0);
      tick();
      m_stall = 1'b1;
      check_val("t4_rsp", 32'(o_rsp_valid), 32'h2);
      #1;
      check_val("t4_rdy_next", 32'(o_req_ready), 32'h2);
      $display("txn t4: grant after pop ready %b", o_req_ready);
      i_req_valid = 4'b0000;

      // 5: orphan result
      do_reset();
      force_orphan = 1'b1;
      #1;
      check_val("t5_rd", 32'(o_lut_rd), 32'h0);
      tick();
      force_orphan = 1'b0;
      check_val("t5_err", 32'(o_err_orphan), 32'h1);
      check_val("t5_rsp", 32'(o_rsp_valid), 32'h0);
      tick();
      check_val("t5_err_sticky", 32'(o_err_orphan), 32'h1);
      check_val("t5_rsp2", 32'(o_rsp_valid), 32'h0);
      tick();
      check_val("t5_err_sticky2", 32'(o_err_orphan), 32'h1);

      // 6: async reset with three lookups outstanding
      do_reset();
      i_req_daddr[127:96] = 32'h0A000303;
      i_req_valid = 4'b1000;
      repeat (3) tick();
      i_req_valid = 4'b0000;
      check_val("t6_pre_dvalid", 32'(o_lut_daddr_valid), 32'h1);
      #2;
      resetn = 1'b0;
      i_req_daddr[31:0]  = 32'h0A0000AA;
      i_req_daddr[95:64] = 32'h0B0000BB;
      i_req_valid = 4'b0101;
      #1;
      check_val("t6_ready",  32'(o_req_ready), 32'h0);
      check_val("t6_rsp",    32'(o_rsp_valid), 32'h0);
      check_val("t6_local",  32'(o_rsp_is_local), 32'h0);
      check_val("t6_dvalid", 32'(o_lut_daddr_valid), 32'h0);
      check_val("t6_daddr",  o_lut_daddr, 32'h0);
      check_val("t6_rd",     32'(o_lut_rd), 32'h0);
      check_val("t6_cnt",    o_lookup_cnt, 32'h0);
      check_val("t6_err",    32'(o_err_orphan), 32'h0);
      repeat (2) tick();
      resetn = 1'b1;
      #1;
      check_val("t6_r0_ready", 32'(o_req_ready), 32'h1);
      tick();
      check_val("t6_r1_daddr", o_lut_daddr, 32'h0A0000AA);
      i_req_valid = 4'b0100;
      #1;
      check_val("t6_r1_ready", 32'(o_req_ready), 32'h4);
      tick();
      i_req_valid = 4'b0000;
      check_val("t6_r2_daddr", o_lut_daddr, 32'h0B0000BB);
      check_val("t6_r2_cnt", o_lookup_cnt, 32'd2);
      for (int r = 2; r <= 8; r++) begin
         if (r > 2) tick();
         check_val($sformatf("t6_rsp%0d", r), 32'(o_rsp_valid),
                   (r == 4) ? 32'h1 : ((r == 5) ? 32'h4 : 32'h0));
         if (r == 4) check_val("t6_loc4", 32'(o_rsp_is_local), 32'h1);
         if (r == 5) check_val("t6_loc5", 32'(o_rsp_is_local), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
